// File: rtl/led_indicator_controller.sv
// Multi-channel LED indicator engine. A shared prescaler produces a one-cycle
// tick, and each channel drives its LED as OFF, ON, BLINK (programmable
// period/on-time in ticks) or ACTIVITY (pulse-stretched activity level).
module led_indicator_controller #(
    parameter int  CHANNELS      = 1,
    parameter int  TICK_CYCLES   = 100000,
    parameter int  PERIOD_WIDTH  = 12,
    parameter int  RESET_PERIOD  = 1000,
    parameter int  RESET_ON_TIME = 10,
    parameter int  STRETCH_TICKS = 50,
    parameter int  ACTIVE_LOW    = 0,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cfg_write,
    input  logic [CH_W-1:0]         i_cfg_channel,
    input  logic [1:0]              i_cfg_mode,
    input  logic [PERIOD_WIDTH-1:0] i_cfg_period,
    input  logic [PERIOD_WIDTH-1:0] i_cfg_on_time,
    input  logic [CHANNELS-1:0]     i_activity,
    output logic                    o_tick,
    output logic [CHANNELS-1:0]     o_led
);

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ON       = 2'd1,
        MODE_BLINK    = 2'd2,
        MODE_ACTIVITY = 2'd3
    } mode_e;

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam int STR_W = $clog2(STRETCH_TICKS + 1);

    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [STR_W-1:0]        STR_LOAD  = STR_W'(STRETCH_TICKS);
    localparam logic [STR_W-1:0]        STR_ONE   = STR_W'(1);
    localparam logic [PERIOD_WIDTH-1:0] PER_RST   = PERIOD_WIDTH'(RESET_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ON_RST    = PERIOD_WIDTH'(RESET_ON_TIME);
    localparam logic [PERIOD_WIDTH-1:0] PH_ONE    = PERIOD_WIDTH'(1);
    localparam logic                    OFF_LEVEL = (ACTIVE_LOW != 0);

    // Prescaler and tick
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Per-channel configuration and running state
    mode_e                   mode_q    [CHANNELS];
    mode_e                   mode_d    [CHANNELS];
    logic [PERIOD_WIDTH-1:0] period_q  [CHANNELS];
    logic [PERIOD_WIDTH-1:0] period_d  [CHANNELS];
    logic [PERIOD_WIDTH-1:0] on_time_q [CHANNELS];
    logic [PERIOD_WIDTH-1:0] on_time_d [CHANNELS];
    logic [PERIOD_WIDTH-1:0] phase_q   [CHANNELS];
    logic [PERIOD_WIDTH-1:0] phase_d   [CHANNELS];
    logic [STR_W-1:0]        stretch_q [CHANNELS];
    logic [STR_W-1:0]        stretch_d [CHANNELS];

    logic [CHANNELS-1:0]     led_q, led_d;

    // Next-state logic for the prescaler, per-channel state and LED levels
    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d    = (cnt_q == CNT_LAST);
        mode_d    = mode_q;
        period_d  = period_q;
        on_time_d = on_time_q;
        phase_d   = phase_q;
        stretch_d = stretch_q;
        led_d     = '0;

        for (int c = 0; c < CHANNELS; c++) begin
            // LED level from the current state; config written this edge shows next edge
            unique case (mode_q[c])
                MODE_OFF:      led_d[c] = 1'b0;
                MODE_ON:       led_d[c] = 1'b1;
                MODE_BLINK:    led_d[c] = (period_q[c] != '0) && (phase_q[c] < on_time_q[c]);
                MODE_ACTIVITY: led_d[c] = (stretch_q[c] != '0);
                default:       led_d[c] = 1'b0;
            endcase
            led_d[c] = led_d[c] ^ OFF_LEVEL;

            // Phase advances on tick and wraps at period-1; a zero period pins it at 0
            if (tick_q) begin
                if ((period_q[c] == '0) || (phase_q[c] >= period_q[c] - PH_ONE)) begin
                    phase_d[c] = '0;
                end else begin
                    phase_d[c] = phase_q[c] + PH_ONE;
                end
            end

            // Activity reloads the stretch counter, which beats the tick decrement
            if (i_activity[c]) begin
                stretch_d[c] = STR_LOAD;
            end else if (tick_q && (stretch_q[c] != '0)) begin
                stretch_d[c] = stretch_q[c] - STR_ONE;
            end

            // A config write to this channel overrides tick and activity updates
            if (i_cfg_write && (i_cfg_channel == CH_W'(c))) begin
                mode_d[c]    = mode_e'(i_cfg_mode);
                period_d[c]  = i_cfg_period;
                on_time_d[c] = i_cfg_on_time;
                phase_d[c]   = '0;
                stretch_d[c] = '0;
            end
        end
    end

    // State registers with asynchronous reset to the legacy blink configuration
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            led_q  <= {CHANNELS{OFF_LEVEL}};
            // NOTE: the per-channel arrays are plain flops, not RAM, and every channel must come out of reset blinking, so each entry is reset.
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]    <= MODE_BLINK;
                period_q[c]  <= PER_RST;
                on_time_q[c] <= ON_RST;
                phase_q[c]   <= '0;
                stretch_q[c] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            led_q     <= led_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            on_time_q <= on_time_d;
            phase_q   <= phase_d;
            stretch_q <= stretch_d;
        end
    end

    assign o_tick = tick_q;
    assign o_led  = led_q;

endmodule
